// File: rtl/ula_seq.sv
// ula_seq: command sequencer in front of a registered 4-bit ULA.
// Queues {a,b,op} commands, issues them one at a time, captures results.
//
// Ports:
//   clk, rst_n             clock, synchronous active-low reset
//   in_valid/in_ready      command handshake; in_a, in_b, in_op payload
//   alu_a/alu_b/alu_op     registered operands to the downstream ULA
//   alu_result/alu_carry   registered result returned by the ULA
//   out_valid/out_ready    result handshake; out_result, out_carry, out_op
//   busy                   queue non-empty or sequencer not idle
module ula_seq #(
    parameter int unsigned DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] in_a,
    input  logic [3:0] in_b,
    input  logic [2:0] in_op,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic [2:0] alu_op,
    input  logic [3:0] alu_result,
    input  logic       alu_carry,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] out_result,
    output logic       out_carry,
    output logic [2:0] out_op,
    output logic       busy
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;

    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
        logic [2:0] op;
    } cmd_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        HOLD
    } state_t;

    // Command queue
    cmd_t          mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Sequencer
    state_t        state_q;
    logic [3:0]    alu_a_q, alu_b_q;
    logic [2:0]    alu_op_q;
    logic          out_valid_q;
    logic [3:0]    out_result_q;
    logic          out_carry_q;
    logic [2:0]    out_op_q;

    logic          push;
    logic          pop;
    logic          not_empty;
    cmd_t          head;
    cmd_t          in_cmd;

    // The ULA only produces a meaningful carry for add/sub.
    function automatic logic carry_kept(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

    assign not_empty = (cnt_q != '0);
    assign in_ready  = rst_n && (cnt_q < CW'(DEPTH));
    assign push      = in_valid && in_ready;

    // A pop happens exactly when the sequencer loads a new command:
    // from IDLE, or from HOLD on the edge the result is consumed.
    always_comb begin
        pop = 1'b0;
        if (rst_n && not_empty) begin
            unique case (state_q)
                IDLE:    pop = 1'b1;
                HOLD:    pop = out_ready;
                default: pop = 1'b0;
            endcase
        end
    end

    assign in_cmd = '{a: in_a, b: in_b, op: in_op};
    assign head   = mem_q[rptr_q];

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (push) begin
            wptr_d = wptr_q + AW'(1);
        end
        if (pop) begin
            rptr_d = rptr_q + AW'(1);
        end
        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Storage needs no reset: pointers and count define what is live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q] <= in_cmd;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_op_q     <= '0;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_carry_q  <= 1'b0;
            out_op_q     <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (pop) begin
                        alu_a_q  <= head.a;
                        alu_b_q  <= head.b;
                        alu_op_q <= head.op;
                        state_q  <= ISSUE;
                    end
                end
                ISSUE: begin
                    // ULA samples alu_* at the end of this cycle.
                    state_q <= WAIT;
                end
                WAIT: begin
                    out_result_q <= alu_result;
                    out_op_q     <= alu_op_q;
                    out_carry_q  <= carry_kept(alu_op_q) ? alu_carry : 1'b0;
                    out_valid_q  <= 1'b1;
                    state_q      <= HOLD;
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        if (pop) begin
                            alu_a_q  <= head.a;
                            alu_b_q  <= head.b;
                            alu_op_q <= head.op;
                            state_q  <= ISSUE;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_op     = alu_op_q;
    assign out_valid  = out_valid_q;
    assign out_result = out_result_q;
    assign out_carry  = out_carry_q;
    assign out_op     = out_op_q;
    assign busy       = not_empty || (state_q != IDLE);

endmodule

// File: tb/tb_ula_seq.sv
// tb_ula_seq: self-checking bench for ula_seq with a registered ULA model.
// Vector table plus hand sequences; results checked through a scoreboard.
module tb_ula_seq;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_a;
    logic [3:0] in_b;
    logic [2:0] in_op;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [2:0] alu_op;
    logic [3:0] alu_result = 4'd0;
    logic       alu_carry  = 1'b0;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_result;
    logic       out_carry;
    logic [2:0] out_op;
    logic       busy;

    always #5 clk = ~clk;

    ula_seq #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_op      (in_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_result (alu_result),
        .alu_carry  (alu_carry),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_carry  (out_carry),
        .out_op     (out_op),
        .busy       (busy)
    );

    // Registered ULA; carry is left untouched by non-arithmetic ops.
    always @(posedge clk) begin
        case (alu_op)
            3'b000:  {alu_carry, alu_result} <= {1'b0, alu_a} + {1'b0, alu_b};
            3'b001:  {alu_carry, alu_result} <= {1'b0, alu_a} - {1'b0, alu_b};
            3'b010:  alu_result <= alu_a & alu_b;
            3'b011:  alu_result <= alu_a | alu_b;
            3'b100:  alu_result <= alu_a ^ alu_b;
            3'b101:  alu_result <= ~alu_a;
            3'b110:  alu_result <= alu_a << 1;
            default: alu_result <= alu_a >> 1;
        endcase
    end

    typedef struct packed {
        logic [3:0] r;
        logic       c;
        logic [2:0] op;
    } exp_t;

    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
        logic [2:0] op;
        logic [3:0] r;
        logic       c;
    } vec_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, want %0h", name, act, req);
    endtask

    // Scoreboard: a result transfers on the next edge when valid && ready.
    always begin
        @(negedge clk);
        #2;
        if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_result: got r=%0d op=%0d, want none",
                         out_result, out_op);
            end else begin
                mon_e = exp_q.pop_front();
                check("sb_result", 32'(out_result), 32'(mon_e.r));
                check("sb_carry", 32'(out_carry), 32'(mon_e.c));
                check("sb_op", 32'(out_op), 32'(mon_e.op));
            end
        end
    end

    // Called on a negedge; returns on the negedge after the accepting edge.
    task automatic push(input logic [3:0] a, input logic [3:0] b,
                        input logic [2:0] op, input logic [3:0] r,
                        input logic c);
        bit ok;
        ok = 1'b0;
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        in_op = op;
        for (int n = 0; n < 64 && !ok; n++) begin
            if (in_ready) begin
                exp_q.push_back('{r: r, c: c, op: op});
                ok = 1'b1;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        if (!ok) begin
            n_checks++;
            $display("FAIL push_timeout: got no accept, want accept");
        end
    endtask

    task automatic wait_drain(input int maxc, input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < maxc) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(exp_q.size()), 32'd0);
    endtask

    vec_t vecs[13];
    exp_t held;
    int   t1, t2, nv;

    initial begin
        vecs[0]  = '{a: 4'd9,  b: 4'd9,  op: 3'b000, r: 4'd2,  c: 1'b1};
        vecs[1]  = '{a: 4'd3,  b: 4'd5,  op: 3'b001, r: 4'd14, c: 1'b1};
        vecs[2]  = '{a: 4'd15, b: 4'd15, op: 3'b000, r: 4'd14, c: 1'b1};
        vecs[3]  = '{a: 4'd12, b: 4'd10, op: 3'b010, r: 4'd8,  c: 1'b0};
        vecs[4]  = '{a: 4'd12, b: 4'd10, op: 3'b011, r: 4'd14, c: 1'b0};
        vecs[5]  = '{a: 4'd12, b: 4'd10, op: 3'b100, r: 4'd6,  c: 1'b0};
        vecs[6]  = '{a: 4'd5,  b: 4'd7,  op: 3'b101, r: 4'd10, c: 1'b0};
        vecs[7]  = '{a: 4'd8,  b: 4'd8,  op: 3'b000, r: 4'd0,  c: 1'b1};
        vecs[8]  = '{a: 4'd9,  b: 4'd0,  op: 3'b110, r: 4'd2,  c: 1'b0};
        vecs[9]  = '{a: 4'd9,  b: 4'd0,  op: 3'b111, r: 4'd4,  c: 1'b0};
        vecs[10] = '{a: 4'd7,  b: 4'd2,  op: 3'b001, r: 4'd5,  c: 1'b0};
        vecs[11] = '{a: 4'd0,  b: 4'd1,  op: 3'b001, r: 4'd15, c: 1'b1};
        vecs[12] = '{a: 4'd0,  b: 4'd0,  op: 3'b000, r: 4'd0,  c: 1'b0};

        rst_n = 1'b0;
        in_valid = 1'b0;
        in_a = '0;
        in_b = '0;
        in_op = '0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);

        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_result", 32'(out_result), 32'd0);
        check("rst_out_carry", 32'(out_carry), 32'd0);
        check("rst_out_op", 32'(out_op), 32'd0);
        check("rst_alu_a", 32'(alu_a), 32'd0);
        check("rst_alu_b", 32'(alu_b), 32'd0);
        check("rst_alu_op", 32'(alu_op), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);

        rst_n = 1'b1;
        #1;
        check("first_in_ready", 32'(in_ready), 32'd1);

        // Latency: accepted at E, visible after E+3 for exactly one cycle.
        push(4'd3, 4'd5, 3'b000, 4'd8, 1'b0);
        begin
            logic [4:0] lat;
            lat = 5'b01000;
            for (int k = 0; k < 5; k++) begin
                check($sformatf("latency_k%0d", k), 32'(out_valid),
                      32'(lat[k]));
                if (k < 4) @(negedge clk);
            end
        end
        wait_drain(20, "drain_latency");

        // Back-to-back: results three cycles apart.
        push(4'd9, 4'd9, 3'b000, 4'd2, 1'b1);
        push(4'd3, 4'd5, 3'b001, 4'd14, 1'b1);
        t1 = -1;
        t2 = -1;
        for (int k = 0; k < 12; k++) begin
            if (out_valid) begin
                if (t1 < 0) t1 = k;
                else if (t2 < 0) t2 = k;
            end
            @(negedge clk);
        end
        check("b2b_spacing", 32'(t2 - t1), 32'd3);
        wait_drain(20, "drain_b2b");

        // Vector table; order keeps a stale ULA carry ahead of logic ops.
        for (int i = 0; i < 13; i++) begin
            push(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].r, vecs[i].c);
            wait_drain(20, $sformatf("drain_vec%0d", i));
        end

        // Backpressure: five accepted, then full; sixth waits.
        out_ready = 1'b0;
        push(4'd1,  4'd2, 3'b000, 4'd3,  1'b0);
        push(4'd4,  4'd4, 3'b001, 4'd0,  1'b0);
        push(4'd6,  4'd3, 3'b011, 4'd7,  1'b0);
        push(4'd15, 4'd1, 3'b000, 4'd0,  1'b1);
        push(4'd2,  4'd3, 3'b001, 4'd15, 1'b1);
        check("full_in_ready", 32'(in_ready), 32'd0);
        check("full_busy", 32'(busy), 32'd1);
        held = '{r: 4'd3, c: 1'b0, op: 3'b000};
        in_valid = 1'b1;
        in_a = 4'd10;
        in_b = 4'd5;
        in_op = 3'b100;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check($sformatf("hold_out_k%0d", k),
                  32'({out_valid, out_result, out_carry, out_op}),
                  32'({1'b1, held}));
            check($sformatf("hold_ready_k%0d", k), 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        push(4'd10, 4'd5, 3'b100, 4'd15, 1'b0);
        wait_drain(60, "drain_full");

        // Reset during WAIT with two queued: everything discarded.
        @(negedge clk);
        push(4'd1, 4'd1, 3'b000, 4'd2, 1'b0);
        push(4'd2, 4'd2, 3'b000, 4'd4, 1'b0);
        push(4'd3, 4'd3, 3'b000, 4'd6, 1'b0);
        check("wait_busy", 32'(busy), 32'd1);
        check("wait_out_valid", 32'(out_valid), 32'd0);
        rst_n = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_outs",
              32'({out_result, out_carry, out_op}), 32'd0);
        check("mid_rst_alu", 32'({alu_a, alu_b, alu_op}), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd0);
        rst_n = 1'b1;
        #1;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
        nv = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (out_valid) nv++;
        end
        check("no_stale_results", 32'(nv), 32'd0);
        check("post_rst_busy", 32'(busy), 32'd0);

        check("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

endmodule
